// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage of the MIPS pipeline and write side of the IF/ID
//   register. Keeps the PC and fetches one instruction at a time over a
//   req/ack memory port. Fetched words are buffered with their PC+4 in a small
//   FIFO whose head drives IF/ID. The stage obeys stalls and redirects on a
//   resolved branch/jump.
//
// Ports
//   clk          in   1   rising-edge clock
//   rst          in   1   synchronous reset, active-low (0 = reset)
//   stall        in   1   hazard unit: hold IF/ID contents
//   redirect     in   1   taken branch/jump resolved this cycle
//   redirect_pc  in   32  target PC for redirect (bits [1:0] ignored)
//   imem_req     out  1   fetch request, held high until imem_ack
//   imem_addr    out  32  fetch address, stable while imem_req=1
//   imem_ack     in   1   imem_rdata valid this cycle (only looked at with req)
//   imem_rdata   in   32  instruction word
//   inst         out  32  FIFO head instruction, NOP_INST when empty
//   adder1       out  32  FIFO head PC+4, 0 when empty
//   ifid_ld      out  1   IF/ID load enable
//   ifid_flush   out  1   IF/ID flush (insert bubble)
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'hFC00_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] adder1,
    output logic        ifid_ld,
    output logic        ifid_flush
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // REQ: fetching at pc. HOLD: FIFO full, no request.
    // DROP: a request issued before a redirect is still outstanding; its
    // response is thrown away.
    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [1:0]    state, state_nxt;
    logic [31:0]   pc, pc_nxt, pc_plus4;
    logic [31:0]   stale_addr;
    logic [31:0]   fifo_inst [DEPTH];
    logic [31:0]   fifo_pc4  [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, count_nxt;
    logic          fifo_empty;
    logic          ack_fire;
    logic          push;
    logic          pop;

    assign pc_plus4   = pc + 32'd4;
    assign fifo_empty = (count == '0);

    // Outputs are forced to their idle values for as long as rst is low, not
    // only after the reset edge.
    assign imem_req   = rst && ((state == S_REQ) || (state == S_DROP));
    // In DROP the old address is kept on the bus until the memory answers.
    assign imem_addr  = (state == S_DROP) ? stale_addr : pc;
    assign ack_fire   = imem_req && imem_ack;

    // A redirect wins over everything: no push of the in-flight word, no pop.
    assign push       = !redirect && ack_fire && (state == S_REQ);
    assign pop        = rst && !redirect && !stall && !fifo_empty;

    assign ifid_ld    = pop;
    assign ifid_flush = rst && (redirect || (!stall && fifo_empty));
    assign inst       = (rst && !fifo_empty) ? fifo_inst[rd_ptr] : NOP_INST;
    assign adder1     = (rst && !fifo_empty) ? fifo_pc4[rd_ptr]  : 32'd0;

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        count_nxt = count + CW'(push) - CW'(pop);

        if (redirect) begin
            pc_nxt    = redirect_pc & 32'hFFFF_FFFC;
            count_nxt = '0;
            // An unanswered request must still be drained before refetching.
            state_nxt = (imem_req && !imem_ack) ? S_DROP : S_REQ;
        end else begin
            case (state)
                S_REQ: begin
                    if (push) begin
                        pc_nxt = pc_plus4;
                    end
                    state_nxt = (count_nxt == FULL) ? S_HOLD : S_REQ;
                end
                S_HOLD: begin
                    if (pop) begin
                        state_nxt = S_REQ;
                    end
                end
                S_DROP: begin
                    if (ack_fire) begin
                        state_nxt = S_REQ;
                    end
                end
                default: state_nxt = S_REQ;
            endcase
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            stale_addr <= RESET_PC;
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            count <= count_nxt;
            // Capture the address on the bus when leaving REQ on a redirect;
            // a redirect while already in DROP keeps the original one.
            if (redirect && (state != S_DROP)) begin
                stale_addr <= pc;
            end
            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
        end
    end

    // NOTE: the FIFO storage has no reset; count gates every read, so stale
    // contents are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_inst[wr_ptr] <= imem_rdata;
            fifo_pc4[wr_ptr]  <= pc_plus4;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Self-checking bench for fetch_unit. A behavioural model (queue of fetched
//   words, current pc, pending-discard flag) predicts every output each cycle.
//   A second instance with RESET_PC=32'hFFFF_FFF8 covers PC wrap-around.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] NOP   = 32'hFC00_0000;
    localparam int          DEPTH = 2;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc4;
    } entry_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic        rst = 1'b0, stall = 1'b0, redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req, imem_ack = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0;
    logic [31:0] inst, adder1;
    logic        ifid_ld, ifid_flush;

    // wrap-around instance
    logic        w_rst = 1'b0, w_stall = 1'b0, w_redirect = 1'b0;
    logic [31:0] w_rpc = '0;
    logic        w_req, w_ack = 1'b0;
    logic [31:0] w_addr, w_rdata = '0;
    logic [31:0] w_inst, w_adder1;
    logic        w_ld, w_flush;

    fetch_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst(inst),
        .adder1(adder1), .ifid_ld(ifid_ld), .ifid_flush(ifid_flush)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk(clk), .rst(w_rst), .stall(w_stall), .redirect(w_redirect),
        .redirect_pc(w_rpc), .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(w_ack), .imem_rdata(w_rdata), .inst(w_inst),
        .adder1(w_adder1), .ifid_ld(w_ld), .ifid_flush(w_flush)
    );

    // planned inputs for the next cycle
    logic        d_rst = 1'b0, d_stall = 1'b0, d_redirect = 1'b0, d_w_rst = 1'b0;
    logic [31:0] d_rpc = '0;
    int          lat = 1;
    bit          rand_mem = 1'b0;
    int          wait_cnt = 0;

    // reference model
    entry_t      mq[$];
    logic [31:0] m_pc = '0, m_stale = '0;
    bit          m_drop = 1'b0;

    // values observed in the most recent cycle
    logic        l_req, l_ld, l_flush, l_w_req, l_w_ld;
    logic [31:0] l_addr, l_adder1, l_w_addr, l_w_adder1, l_w_inst;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, answer the memory, compare with the
    // model, then advance the model across the rising edge.
    task automatic cycle();
        logic        e_req, e_ld, e_flush, fire;
        logic [31:0] e_inst, e_adder1, e_addr;
        entry_t      ent;

        @(negedge clk);
        rst         = d_rst;
        stall       = d_stall;
        redirect    = d_redirect;
        redirect_pc = d_rpc;
        w_rst       = d_w_rst;
        #1;
        if (imem_req) begin
            if (rand_mem) imem_ack = ($urandom_range(0, 1) == 1);
            else          imem_ack = (wait_cnt + 1 >= lat);
            imem_rdata = imem_ack ? inst_of(imem_addr) : $urandom;
        end else begin
            // junk ack while idle must be ignored
            imem_ack   = ($urandom_range(0, 1) == 1);
            imem_rdata = $urandom;
        end
        w_ack   = w_req;
        w_rdata = inst_of(w_addr);
        #1;

        if (!rst) begin
            e_req = 1'b0; e_inst = NOP; e_adder1 = '0; e_ld = 1'b0; e_flush = 1'b0;
        end else begin
            e_req    = m_drop || (mq.size() < DEPTH);
            e_inst   = (mq.size() > 0) ? mq[0].inst : NOP;
            e_adder1 = (mq.size() > 0) ? mq[0].pc4  : 32'd0;
            e_flush  = redirect || (!stall && mq.size() == 0);
            e_ld     = !redirect && !stall && (mq.size() > 0);
        end
        e_addr = m_drop ? m_stale : m_pc;

        check("imem_req", 32'(imem_req), 32'(e_req));
        if (e_req) check("imem_addr", imem_addr, e_addr);
        check("inst", inst, e_inst);
        check("adder1", adder1, e_adder1);
        check("ifid_ld", 32'(ifid_ld), 32'(e_ld));
        check("ifid_flush", 32'(ifid_flush), 32'(e_flush));

        l_req = imem_req; l_addr = imem_addr; l_ld = ifid_ld;
        l_adder1 = adder1; l_flush = ifid_flush;
        l_w_req = w_req; l_w_addr = w_addr; l_w_ld = w_ld;
        l_w_adder1 = w_adder1; l_w_inst = w_inst;
        fire = e_req && imem_ack;

        @(posedge clk);
        if (!rst) begin
            m_pc = 32'h0; mq.delete(); m_drop = 1'b0;
        end else if (redirect) begin
            if (!m_drop) m_stale = m_pc;
            m_drop = e_req && !fire;
            mq.delete();
            m_pc = redirect_pc & ~32'h3;
        end else if (m_drop) begin
            if (fire) m_drop = 1'b0;
        end else begin
            if (e_ld) void'(mq.pop_front());
            if (fire) begin
                ent.inst = imem_rdata;
                ent.pc4  = m_pc + 32'd4;
                mq.push_back(ent);
                m_pc = m_pc + 32'd4;
            end
        end

        if (!rst)        wait_cnt = 0;
        else if (l_req)  wait_cnt = imem_ack ? 0 : wait_cnt + 1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;

        // reset
        repeat (3) cycle();
        check("rst_req", 32'(l_req), 32'd0);
        check("rst_flush", 32'(l_flush), 32'd0);
        check("w_rst_inst", l_w_inst, NOP);
        check("w_rst_req", 32'(l_w_req), 32'd0);

        // 1: single-cycle memory, no stall
        d_rst = 1'b1; lat = 1;
        cycle();
        check("t1_first_addr", l_addr, 32'h0);
        for (int k = 1; k <= 7; k++) begin
            cycle();
            check("t1_ld", 32'(l_ld), 32'd1);
            check("t1_adder1", l_adder1, 32'(4 * k));
        end

        // 2: stall for 5 cycles, FIFO fills and request stops
        d_stall = 1'b1;
        repeat (5) cycle();
        check("t2_hold_req", 32'(l_req), 32'd0);
        check("t2_stall_ld", 32'(l_ld), 32'd0);
        d_stall = 1'b0;
        cycle();
        check("t2_rel_ld0", 32'(l_ld), 32'd1);
        check("t2_rel_adder0", l_adder1, 32'd32);
        cycle();
        check("t2_rel_ld1", 32'(l_ld), 32'd1);
        check("t2_rel_adder1", l_adder1, 32'd36);

        // 3: three-cycle memory latency
        lat = 3;
        repeat (24) cycle();

        // 4: redirect while the request to 0x8 is pending
        d_rst = 1'b0; cycle(); d_rst = 1'b1;
        repeat (7) cycle();
        d_redirect = 1'b1; d_rpc = 32'h100;
        cycle();
        check("t4_pending_addr", l_addr, 32'h8);
        check("t4_flush", 32'(l_flush), 32'd1);
        d_redirect = 1'b0;
        cycle();
        check("t4_drop_addr", l_addr, 32'h8);
        cycle();
        check("t4_new_addr", l_addr, 32'h100);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            cycle();
            if (l_ld) found = 1'b1;
        end
        check("t4_ld_seen", 32'(found), 32'd1);
        check("t4_adder1", l_adder1, 32'h104);

        // 5a: redirect together with an ack
        lat = 1;
        repeat (4) cycle();
        d_redirect = 1'b1; d_rpc = 32'h0000_2003;
        cycle();
        check("t5_ack_req", 32'(l_req), 32'd1);
        check("t5_flush", 32'(l_flush), 32'd1);
        d_redirect = 1'b0;
        cycle();
        check("t5_new_addr", l_addr, 32'h2000);
        check("t5_no_stale_ld", 32'(l_ld), 32'd0);
        cycle();
        check("t5_adder1", l_adder1, 32'h2004);

        // 5b: redirect during stall
        d_stall = 1'b1;
        repeat (4) cycle();
        d_redirect = 1'b1; d_rpc = 32'h3000;
        cycle();
        check("t5s_flush", 32'(l_flush), 32'd1);
        check("t5s_ld", 32'(l_ld), 32'd0);
        d_redirect = 1'b0; d_stall = 1'b0;
        cycle();
        check("t5s_addr", l_addr, 32'h3000);
        cycle();
        check("t5s_adder1", l_adder1, 32'h3004);

        // randomized traffic: random ack, stall, redirect, occasional reset
        rand_mem = 1'b1;
        for (int i = 0; i < 800; i++) begin
            d_stall    = ($urandom_range(0, 9) < 3);
            d_redirect = ($urandom_range(0, 19) == 0);
            d_rpc      = $urandom;
            d_rst      = ($urandom_range(0, 99) != 0);
            cycle();
        end
        d_rst = 1'b1; d_stall = 1'b0; d_redirect = 1'b0;

        // 6a: reset in the middle of a request
        rand_mem = 1'b0; lat = 3;
        d_rst = 1'b0; cycle();
        d_rst = 1'b1; cycle();
        check("t6_req_pending", 32'(l_req), 32'd1);
        d_rst = 1'b0; cycle();
        check("t6_rst_req", 32'(l_req), 32'd0);
        check("t6_rst_adder1", l_adder1, 32'd0);
        check("t6_rst_flush", 32'(l_flush), 32'd0);
        d_rst = 1'b1; cycle();
        check("t6_restart_addr", l_addr, 32'h0);

        // 6b: PC wrap-around on the second instance
        d_w_rst = 1'b1;
        cycle();
        check("t6w_addr0", l_w_addr, 32'hFFFF_FFF8);
        check("t6w_req0", 32'(l_w_req), 32'd1);
        cycle();
        check("t6w_addr1", l_w_addr, 32'hFFFF_FFFC);
        check("t6w_ld1", 32'(l_w_ld), 32'd1);
        check("t6w_adder1_1", l_w_adder1, 32'hFFFF_FFFC);
        cycle();
        check("t6w_addr2", l_w_addr, 32'h0);
        check("t6w_adder1_2", l_w_adder1, 32'h0);
        check("t6w_ld2", 32'(l_w_ld), 32'd1);
        cycle();
        check("t6w_addr3", l_w_addr, 32'h4);
        check("t6w_adder1_3", l_w_adder1, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
